// File: rtl/tsl_rtl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tsl_rtl_pkg
//  Description : Shared definitions for the lane-wise mask blocks
//                (mask_expand / mask_compress). Holds the default lane
//                geometry, the lane-index type and a lane-slice helper.
//  Config      : none
//  Revision    : 1.0  initial release
// ============================================================================
package tsl_rtl_pkg;

    // Default geometry. Modules take their own VECTOR_SIZE / DATA_WIDTH
    // parameters defaulting to these, so these carry a _DEF suffix to keep
    // them distinct from the module-level parameter names.
    localparam int VECTOR_SIZE_DEF = 8;
    localparam int DATA_WIDTH_DEF  = 64;

    localparam int LANE_IDX_W = $clog2(VECTOR_SIZE_DEF);

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    // Extract one lane from a flattened vector (default geometry).
    function automatic logic [DATA_WIDTH_DEF-1:0] lane_get(
        input logic [VECTOR_SIZE_DEF*DATA_WIDTH_DEF-1:0] vec,
        input lane_idx_t                                 lane
    );
        return vec[int'(lane)*DATA_WIDTH_DEF +: DATA_WIDTH_DEF];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mask_prefix_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : mask_prefix_popcount
//  Description : Combinational exclusive prefix popcount of a lane mask.
//                o_idx[i] = number of set bits in i_mask[i-1:0], o_idx[0]=0.
//                For a set lane this is its rank among the selected lanes,
//                which is the packed-source lane it reads (expand) or the
//                packed-destination lane it writes (compress).
//  Ports       : i_mask  [VECTOR_SIZE]        lane mask
//                o_idx   [VECTOR_SIZE][IDX_W] per-lane prefix count
//  Config      : none
//  Revision    : 1.0  initial release
// ============================================================================
module mask_prefix_popcount
    import tsl_rtl_pkg::*;
#(
    parameter int VECTOR_SIZE = VECTOR_SIZE_DEF,
    parameter int IDX_W       = $clog2(VECTOR_SIZE)
) (
    input  logic [VECTOR_SIZE-1:0] i_mask,
    output logic [IDX_W-1:0]       o_idx [VECTOR_SIZE]
);

    logic [IDX_W-1:0] w_acc;

    // Running sum; the count never exceeds VECTOR_SIZE-1 at any lane it is
    // written to, so IDX_W bits suffice (the final increment is discarded).
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < VECTOR_SIZE; i++) begin
            o_idx[i] = w_acc;
            w_acc    = w_acc + IDX_W'(i_mask[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mask_expand_module.sv
`default_nettype none
// ============================================================================
//  Module      : mask_expand_module
//  Description : Lane-wise masked expand (inverse of mask_compress). The low
//                popcount(mask) lanes of datain_a are scattered in order to
//                the lanes whose mask bit is set; the remaining lanes take
//                datain_src (or zero when zmask is set). Two registered
//                stages with valid/ready backpressure, 1 vector/cycle.
//  Ports       : clock, reset (sync, active-high)
//                ivalid/oready  upstream handshake
//                ovalid/iready  downstream handshake
//                datain_src, datain_a [VECTOR_SIZE*DATA_WIDTH], maskin
//                zmask          (only with MASK_EXPAND_ZEROMASK_EN)
//                dataout        registered expanded vector
//  Config      : `MASK_EXPAND_ZEROMASK_EN adds the zmask input.
//  Revision    : 1.0  initial release
// ============================================================================
module mask_expand_module
    import tsl_rtl_pkg::*;
#(
    parameter int VECTOR_SIZE = VECTOR_SIZE_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            ivalid,
    output logic                            oready,
    output logic                            ovalid,
    input  logic                            iready,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] datain_src,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] datain_a,
    input  logic [VECTOR_SIZE-1:0]          maskin,
`ifdef MASK_EXPAND_ZEROMASK_EN
    input  logic                            zmask,
`endif
    output logic [VECTOR_SIZE*DATA_WIDTH-1:0] dataout
);

    localparam int c_IDX_W = $clog2(VECTOR_SIZE);
    localparam int c_VEC_W = VECTOR_SIZE * DATA_WIDTH;

    logic                   w_en;
    logic                   w_zmask;
    logic [c_IDX_W-1:0]     w_idx [VECTOR_SIZE];

    logic                   r_s1_valid;
    logic [c_VEC_W-1:0]     r_s1_src;
    logic [c_VEC_W-1:0]     r_s1_a;
    logic [VECTOR_SIZE-1:0] r_s1_mask;
    logic [c_IDX_W-1:0]     r_s1_idx [VECTOR_SIZE];
    logic                   r_s1_zmask;

    logic                   r_ovalid;
    logic [c_VEC_W-1:0]     r_dataout;

    logic [DATA_WIDTH-1:0]  w_a_lane [VECTOR_SIZE];
    logic [c_VEC_W-1:0]     w_expand;

`ifdef MASK_EXPAND_ZEROMASK_EN
    assign w_zmask = zmask;
`else
    assign w_zmask = 1'b0;
`endif

    // Whole pipeline advances together unless the output holds an
    // unconsumed result.
    assign w_en   = ~r_ovalid | iready;
    assign oready = w_en;
    assign ovalid = r_ovalid;
    assign dataout = r_dataout;

    mask_prefix_popcount #(
        .VECTOR_SIZE (VECTOR_SIZE),
        .IDX_W       (c_IDX_W)
    ) u_prefix (
        .i_mask (maskin),
        .o_idx  (w_idx)
    );

    // Stage 1: capture operands and per-lane source index.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_src   <= '0;
            r_s1_a     <= '0;
            r_s1_mask  <= '0;
            r_s1_idx   <= '{default: '0};
            r_s1_zmask <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= ivalid;
            // Data only matters in a valid slot; skip loading bubbles.
            if (ivalid) begin
                r_s1_src   <= datain_src;
                r_s1_a     <= datain_a;
                r_s1_mask  <= maskin;
                r_s1_idx   <= w_idx;
                r_s1_zmask <= w_zmask;
            end
        end
    end

    // Stage 2 lane muxes.
    for (genvar i = 0; i < VECTOR_SIZE; i++) begin : g_lane
        assign w_a_lane[i] = r_s1_a[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_expand[i*DATA_WIDTH +: DATA_WIDTH] =
            r_s1_mask[i] ? w_a_lane[r_s1_idx[i]] :
            r_s1_zmask   ? '0 :
                           r_s1_src[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Stage 2: output register. Loading only valid slots keeps dataout
    // stable across bubbles.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovalid  <= 1'b0;
            r_dataout <= '0;
        end else if (w_en) begin
            r_ovalid <= r_s1_valid;
            if (r_s1_valid) begin
                r_dataout <= w_expand;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mask_expand_module.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mask_expand_module
//  Description : Self-checking bench for mask_expand_module (8 lanes x 64b).
//                Directed vectors with hand-computed results, a stall and a
//                mid-flight reset, then a randomised valid/ready run checked
//                against a scoreboard. Define MASK_EXPAND_ZEROMASK_EN to
//                exercise the zmask variant.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mask_expand_module;
    import tsl_rtl_pkg::*;

    localparam int VS = 8;
    localparam int DW = 64;
    localparam int VW = VS * DW;

    logic          clock = 1'b0;
    logic          reset;
    logic          ivalid;
    logic          oready;
    logic          ovalid;
    logic          iready;
    logic [VW-1:0] datain_src;
    logic [VW-1:0] datain_a;
    logic [VS-1:0] maskin;
    logic [VW-1:0] dataout;
`ifdef MASK_EXPAND_ZEROMASK_EN
    logic          zmask;
`endif

    always #5 clock = ~clock;

    mask_expand_module #(
        .VECTOR_SIZE (VS),
        .DATA_WIDTH  (DW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ivalid     (ivalid),
        .oready     (oready),
        .ovalid     (ovalid),
        .iready     (iready),
        .datain_src (datain_src),
        .datain_a   (datain_a),
        .maskin     (maskin),
`ifdef MASK_EXPAND_ZEROMASK_EN
        .zmask      (zmask),
`endif
        .dataout    (dataout)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_out  = 0;

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [VW-1:0] vec8(input logic [7:0] l0, l1, l2, l3,
                                            input logic [7:0] l4, l5, l6, l7);
        logic [VW-1:0] v;
        v = '0;
        v[0*DW +: 8] = l0; v[1*DW +: 8] = l1; v[2*DW +: 8] = l2; v[3*DW +: 8] = l3;
        v[4*DW +: 8] = l4; v[5*DW +: 8] = l5; v[6*DW +: 8] = l6; v[7*DW +: 8] = l7;
        return v;
    endfunction

    // Reference: walk the lanes, consuming packed source lanes in order.
    function automatic logic [VW-1:0] expand_ref(input logic [VW-1:0] src, input logic [VW-1:0] a,
                                                  input logic [VS-1:0] m, input logic z);
        logic [VW-1:0] r;
        int k;
        k = 0;
        r = '0;
        for (int i = 0; i < VS; i++) begin
            if (m[i]) begin
                r[i*DW +: DW] = lane_get(a, lane_idx_t'(k));
                k++;
            end else begin
                r[i*DW +: DW] = z ? '0 : lane_get(src, lane_idx_t'(i));
            end
        end
        return r;
    endfunction

    // Scoreboard and stability monitor, sampled mid-cycle.
    logic [VW-1:0] sb_q [$];
    logic [VW-1:0] last_out;
    logic          prev_reset = 1'b1;
    logic          prev_stall = 1'b0;
    logic          cur_z;

    always @(negedge clock) begin
`ifdef MASK_EXPAND_ZEROMASK_EN
        cur_z = zmask;
`else
        cur_z = 1'b0;
`endif
        if (!prev_reset) begin
            if (prev_stall) begin
                chk("stall_hold", dataout, last_out);
                chk("stall_ovalid", VW'(ovalid), VW'(1));
            end else if (!ovalid) begin
                chk("bubble_stable", dataout, last_out);
            end
        end
        if (reset) begin
            sb_q.delete();
        end else begin
            if (ovalid && iready) begin
                n_out++;
                chk("sb_nonempty", VW'(sb_q.size() != 0), VW'(1));
                if (sb_q.size() != 0) chk("sb_data", dataout, sb_q.pop_front());
            end
            if (ivalid && oready) sb_q.push_back(expand_ref(datain_src, datain_a, maskin, cur_z));
        end
        prev_reset = reset;
        prev_stall = ovalid && !iready && !reset;
        last_out   = dataout;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic rand_data;
        for (int w = 0; w < VW / 32; w++) begin
            datain_src[w*32 +: 32] = $urandom();
            datain_a[w*32 +: 32]   = $urandom();
        end
        maskin = VS'($urandom_range(255));
`ifdef MASK_EXPAND_ZEROMASK_EN
        zmask = 1'($urandom_range(1));
`endif
    endtask

    logic [VW-1:0] c_src, c_a, held;
    logic [7:0]    t3_mask [4];
    logic          acc;
    int            sent, cyc, out0;

    initial begin
        c_src = vec8(8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57);
        c_a   = vec8(8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7);
        t3_mask = '{8'h66, 8'h0F, 8'hF0, 8'h3C};

        reset = 1'b1; ivalid = 1'b0; iready = 1'b1; maskin = '0;
        datain_src = c_src; datain_a = c_a;
`ifdef MASK_EXPAND_ZEROMASK_EN
        zmask = 1'b0;
`endif
        tick; tick;
        chk("rst_ovalid",  VW'(ovalid), VW'(0));
        chk("rst_dataout", dataout, '0);
        chk("rst_oready",  VW'(oready), VW'(1));
        reset = 1'b0;
        tick;

        // Test 1: mask 0x66, 2-cycle latency, single-cycle ovalid
        ivalid = 1'b1; maskin = 8'h66;
        tick;
        ivalid = 1'b0;
        chk("t1_not_early", VW'(ovalid), VW'(0));
        tick;
        chk("t1_ovalid", VW'(ovalid), VW'(1));
        chk("t1_data", dataout, vec8(8'h50, 8'hA0, 8'hA1, 8'h53, 8'h54, 8'hA2, 8'hA3, 8'h57));
        tick;
        chk("t1_ovalid_drop", VW'(ovalid), VW'(0));
        chk("t1_data_stable", dataout, vec8(8'h50, 8'hA0, 8'hA1, 8'h53, 8'h54, 8'hA2, 8'hA3, 8'h57));

        // Test 2: back-to-back 0x00, 0xFF, 0x80
        ivalid = 1'b1; maskin = 8'h00;
        tick;
        maskin = 8'hFF;
        tick;
        chk("t2_mask00", dataout, c_src);
        maskin = 8'h80;
        tick;
        ivalid = 1'b0;
        chk("t2_maskFF", dataout, c_a);
        tick;
        chk("t2_mask80", dataout, vec8(8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'hA0));
        chk("t2_ovalid", VW'(ovalid), VW'(1));
        tick; tick;

        // Test 3: four vectors, iready low on cycles 3..5
        sent = 0; cyc = 0; out0 = n_out; held = '0;
        while ((sent < 4 || n_out - out0 < 4) && cyc < 40) begin
            iready = !(cyc >= 3 && cyc <= 5);
            if (sent < 4) begin
                ivalid = 1'b1; maskin = t3_mask[sent];
            end else begin
                ivalid = 1'b0;
            end
            #1;
            if (cyc >= 3 && cyc <= 5) begin
                chk("t3_oready_stall", VW'(oready), VW'(0));
                if (cyc == 3) held = dataout;
                else chk("t3_hold", dataout, held);
            end
            acc = ivalid && oready;
            tick;
            if (acc) sent++;
            cyc++;
        end
        chk("t3_count", VW'(n_out - out0), VW'(4));
        ivalid = 1'b0; iready = 1'b1;
        tick;

        // Test 4: reset with two vectors in flight
        ivalid = 1'b1; maskin = 8'h0F;
        tick;
        maskin = 8'h33;
        tick;
        ivalid = 1'b0; reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("t4_ovalid", VW'(ovalid), VW'(0));
        chk("t4_dataout", dataout, '0);
        chk("t4_oready", VW'(oready), VW'(1));
        ivalid = 1'b1; maskin = 8'h01;
        tick;
        ivalid = 1'b0;
        tick;
        chk("t4_new_ovalid", VW'(ovalid), VW'(1));
        chk("t4_new_data", dataout, vec8(8'hA0, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57));
        tick;

`ifdef MASK_EXPAND_ZEROMASK_EN
        // Test 5: zero-masking
        ivalid = 1'b1; maskin = 8'h81; zmask = 1'b1;
        tick;
        zmask = 1'b0;
        tick;
        ivalid = 1'b0;
        chk("t5_zmask1", dataout, vec8(8'hA0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA1));
        tick;
        chk("t5_zmask0", dataout, vec8(8'hA0, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'hA1));
        tick;
`endif

        // Test 6: random traffic against the scoreboard
        sent = 0; cyc = 0; out0 = n_out; ivalid = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            iready = ($urandom_range(3) != 0);
            if (!ivalid && $urandom_range(3) != 0) begin
                ivalid = 1'b1;
                rand_data();
            end
            #1;
            acc = ivalid && oready;
            tick;
            cyc++;
            if (acc) begin
                sent++;
                if ($urandom_range(3) != 0) rand_data();
                else ivalid = 1'b0;
            end
        end
        chk("t6_sent", VW'(sent), VW'(10000));
        ivalid = 1'b0; iready = 1'b1;
        repeat (4) tick;
        chk("t6_drain", VW'(sb_q.size()), VW'(0));
        chk("t6_count", VW'(n_out - out0), VW'(10000));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
